// File: rtl/aes_pkg.sv
// Shared definitions for the serial AES round engines: widths, the byte
// position helper and the common engine state encoding.
package aes_pkg;

    localparam int AES_BYTE_W  = 8;
    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;

    // Common state encoding for the byte-serial round engines.
    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_BUSY = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    // Byte 0 sits in the most significant slice of the state word.
    function automatic int byte_lsb(input int idx);
        return AES_STATE_W - (AES_BYTE_W * (idx + 1));
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Input and output valid/ready channels of the serial InvSubBytes engine.
interface inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [AES_STATE_W-1:0] in_state;
    logic                   out_valid;
    logic                   out_ready;
    logic [AES_STATE_W-1:0] out_state;
    logic                   busy;

    // Engine side.
    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state,
        output busy
    );

    // Producer / consumer side.
    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state,
        input  busy
    );

endinterface

// File: rtl/inv_sbox.sv
// AES inverse S-box: one byte in, one byte out, purely combinational.
module inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Inverse substitution table lookup.
    always_comb begin
        o_byte = 8'h00;
        case (i_byte)
            8'h00: o_byte = 8'h52; 8'h01: o_byte = 8'h09; 8'h02: o_byte = 8'h6a; 8'h03: o_byte = 8'hd5; 8'h04: o_byte = 8'h30; 8'h05: o_byte = 8'h36; 8'h06: o_byte = 8'ha5; 8'h07: o_byte = 8'h38;
            8'h08: o_byte = 8'hbf; 8'h09: o_byte = 8'h40; 8'h0a: o_byte = 8'ha3; 8'h0b: o_byte = 8'h9e; 8'h0c: o_byte = 8'h81; 8'h0d: o_byte = 8'hf3; 8'h0e: o_byte = 8'hd7; 8'h0f: o_byte = 8'hfb;
            8'h10: o_byte = 8'h7c; 8'h11: o_byte = 8'he3; 8'h12: o_byte = 8'h39; 8'h13: o_byte = 8'h82; 8'h14: o_byte = 8'h9b; 8'h15: o_byte = 8'h2f; 8'h16: o_byte = 8'hff; 8'h17: o_byte = 8'h87;
            8'h18: o_byte = 8'h34; 8'h19: o_byte = 8'h8e; 8'h1a: o_byte = 8'h43; 8'h1b: o_byte = 8'h44; 8'h1c: o_byte = 8'hc4; 8'h1d: o_byte = 8'hde; 8'h1e: o_byte = 8'he9; 8'h1f: o_byte = 8'hcb;
            8'h20: o_byte = 8'h54; 8'h21: o_byte = 8'h7b; 8'h22: o_byte = 8'h94; 8'h23: o_byte = 8'h32; 8'h24: o_byte = 8'ha6; 8'h25: o_byte = 8'hc2; 8'h26: o_byte = 8'h23; 8'h27: o_byte = 8'h3d;
            8'h28: o_byte = 8'hee; 8'h29: o_byte = 8'h4c; 8'h2a: o_byte = 8'h95; 8'h2b: o_byte = 8'h0b; 8'h2c: o_byte = 8'h42; 8'h2d: o_byte = 8'hfa; 8'h2e: o_byte = 8'hc3; 8'h2f: o_byte = 8'h4e;
            8'h30: o_byte = 8'h08; 8'h31: o_byte = 8'h2e; 8'h32: o_byte = 8'ha1; 8'h33: o_byte = 8'h66; 8'h34: o_byte = 8'h28; 8'h35: o_byte = 8'hd9; 8'h36: o_byte = 8'h24; 8'h37: o_byte = 8'hb2;
            8'h38: o_byte = 8'h76; 8'h39: o_byte = 8'h5b; 8'h3a: o_byte = 8'ha2; 8'h3b: o_byte = 8'h49; 8'h3c: o_byte = 8'h6d; 8'h3d: o_byte = 8'h8b; 8'h3e: o_byte = 8'hd1; 8'h3f: o_byte = 8'h25;
            8'h40: o_byte = 8'h72; 8'h41: o_byte = 8'hf8; 8'h42: o_byte = 8'hf6; 8'h43: o_byte = 8'h64; 8'h44: o_byte = 8'h86; 8'h45: o_byte = 8'h68; 8'h46: o_byte = 8'h98; 8'h47: o_byte = 8'h16;
            8'h48: o_byte = 8'hd4; 8'h49: o_byte = 8'ha4; 8'h4a: o_byte = 8'h5c; 8'h4b: o_byte = 8'hcc; 8'h4c: o_byte = 8'h5d; 8'h4d: o_byte = 8'h65; 8'h4e: o_byte = 8'hb6; 8'h4f: o_byte = 8'h92;
            8'h50: o_byte = 8'h6c; 8'h51: o_byte = 8'h70; 8'h52: o_byte = 8'h48; 8'h53: o_byte = 8'h50; 8'h54: o_byte = 8'hfd; 8'h55: o_byte = 8'hed; 8'h56: o_byte = 8'hb9; 8'h57: o_byte = 8'hda;
            8'h58: o_byte = 8'h5e; 8'h59: o_byte = 8'h15; 8'h5a: o_byte = 8'h46; 8'h5b: o_byte = 8'h57; 8'h5c: o_byte = 8'ha7; 8'h5d: o_byte = 8'h8d; 8'h5e: o_byte = 8'h9d; 8'h5f: o_byte = 8'h84;
            8'h60: o_byte = 8'h90; 8'h61: o_byte = 8'hd8; 8'h62: o_byte = 8'hab; 8'h63: o_byte = 8'h00; 8'h64: o_byte = 8'h8c; 8'h65: o_byte = 8'hbc; 8'h66: o_byte = 8'hd3; 8'h67: o_byte = 8'h0a;
            8'h68: o_byte = 8'hf7; 8'h69: o_byte = 8'he4; 8'h6a: o_byte = 8'h58; 8'h6b: o_byte = 8'h05; 8'h6c: o_byte = 8'hb8; 8'h6d: o_byte = 8'hb3; 8'h6e: o_byte = 8'h45; 8'h6f: o_byte = 8'h06;
            8'h70: o_byte = 8'hd0; 8'h71: o_byte = 8'h2c; 8'h72: o_byte = 8'h1e; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'hca; 8'h75: o_byte = 8'h3f; 8'h76: o_byte = 8'h0f; 8'h77: o_byte = 8'h02;
            8'h78: o_byte = 8'hc1; 8'h79: o_byte = 8'haf; 8'h7a: o_byte = 8'hbd; 8'h7b: o_byte = 8'h03; 8'h7c: o_byte = 8'h01; 8'h7d: o_byte = 8'h13; 8'h7e: o_byte = 8'h8a; 8'h7f: o_byte = 8'h6b;
            8'h80: o_byte = 8'h3a; 8'h81: o_byte = 8'h91; 8'h82: o_byte = 8'h11; 8'h83: o_byte = 8'h41; 8'h84: o_byte = 8'h4f; 8'h85: o_byte = 8'h67; 8'h86: o_byte = 8'hdc; 8'h87: o_byte = 8'hea;
            8'h88: o_byte = 8'h97; 8'h89: o_byte = 8'hf2; 8'h8a: o_byte = 8'hcf; 8'h8b: o_byte = 8'hce; 8'h8c: o_byte = 8'hf0; 8'h8d: o_byte = 8'hb4; 8'h8e: o_byte = 8'he6; 8'h8f: o_byte = 8'h73;
            8'h90: o_byte = 8'h96; 8'h91: o_byte = 8'hac; 8'h92: o_byte = 8'h74; 8'h93: o_byte = 8'h22; 8'h94: o_byte = 8'he7; 8'h95: o_byte = 8'had; 8'h96: o_byte = 8'h35; 8'h97: o_byte = 8'h85;
            8'h98: o_byte = 8'he2; 8'h99: o_byte = 8'hf9; 8'h9a: o_byte = 8'h37; 8'h9b: o_byte = 8'he8; 8'h9c: o_byte = 8'h1c; 8'h9d: o_byte = 8'h75; 8'h9e: o_byte = 8'hdf; 8'h9f: o_byte = 8'h6e;
            8'ha0: o_byte = 8'h47; 8'ha1: o_byte = 8'hf1; 8'ha2: o_byte = 8'h1a; 8'ha3: o_byte = 8'h71; 8'ha4: o_byte = 8'h1d; 8'ha5: o_byte = 8'h29; 8'ha6: o_byte = 8'hc5; 8'ha7: o_byte = 8'h89;
            8'ha8: o_byte = 8'h6f; 8'ha9: o_byte = 8'hb7; 8'haa: o_byte = 8'h62; 8'hab: o_byte = 8'h0e; 8'hac: o_byte = 8'haa; 8'had: o_byte = 8'h18; 8'hae: o_byte = 8'hbe; 8'haf: o_byte = 8'h1b;
            8'hb0: o_byte = 8'hfc; 8'hb1: o_byte = 8'h56; 8'hb2: o_byte = 8'h3e; 8'hb3: o_byte = 8'h4b; 8'hb4: o_byte = 8'hc6; 8'hb5: o_byte = 8'hd2; 8'hb6: o_byte = 8'h79; 8'hb7: o_byte = 8'h20;
            8'hb8: o_byte = 8'h9a; 8'hb9: o_byte = 8'hdb; 8'hba: o_byte = 8'hc0; 8'hbb: o_byte = 8'hfe; 8'hbc: o_byte = 8'h78; 8'hbd: o_byte = 8'hcd; 8'hbe: o_byte = 8'h5a; 8'hbf: o_byte = 8'hf4;
            8'hc0: o_byte = 8'h1f; 8'hc1: o_byte = 8'hdd; 8'hc2: o_byte = 8'ha8; 8'hc3: o_byte = 8'h33; 8'hc4: o_byte = 8'h88; 8'hc5: o_byte = 8'h07; 8'hc6: o_byte = 8'hc7; 8'hc7: o_byte = 8'h31;
            8'hc8: o_byte = 8'hb1; 8'hc9: o_byte = 8'h12; 8'hca: o_byte = 8'h10; 8'hcb: o_byte = 8'h59; 8'hcc: o_byte = 8'h27; 8'hcd: o_byte = 8'h80; 8'hce: o_byte = 8'hec; 8'hcf: o_byte = 8'h5f;
            8'hd0: o_byte = 8'h60; 8'hd1: o_byte = 8'h51; 8'hd2: o_byte = 8'h7f; 8'hd3: o_byte = 8'ha9; 8'hd4: o_byte = 8'h19; 8'hd5: o_byte = 8'hb5; 8'hd6: o_byte = 8'h4a; 8'hd7: o_byte = 8'h0d;
            8'hd8: o_byte = 8'h2d; 8'hd9: o_byte = 8'he5; 8'hda: o_byte = 8'h7a; 8'hdb: o_byte = 8'h9f; 8'hdc: o_byte = 8'h93; 8'hdd: o_byte = 8'hc9; 8'hde: o_byte = 8'h9c; 8'hdf: o_byte = 8'hef;
            8'he0: o_byte = 8'ha0; 8'he1: o_byte = 8'he0; 8'he2: o_byte = 8'h3b; 8'he3: o_byte = 8'h4d; 8'he4: o_byte = 8'hae; 8'he5: o_byte = 8'h2a; 8'he6: o_byte = 8'hf5; 8'he7: o_byte = 8'hb0;
            8'he8: o_byte = 8'hc8; 8'he9: o_byte = 8'heb; 8'hea: o_byte = 8'hbb; 8'heb: o_byte = 8'h3c; 8'hec: o_byte = 8'h83; 8'hed: o_byte = 8'h53; 8'hee: o_byte = 8'h99; 8'hef: o_byte = 8'h61;
            8'hf0: o_byte = 8'h17; 8'hf1: o_byte = 8'h2b; 8'hf2: o_byte = 8'h04; 8'hf3: o_byte = 8'h7e; 8'hf4: o_byte = 8'hba; 8'hf5: o_byte = 8'h77; 8'hf6: o_byte = 8'hd6; 8'hf7: o_byte = 8'h26;
            8'hf8: o_byte = 8'he1; 8'hf9: o_byte = 8'h69; 8'hfa: o_byte = 8'h14; 8'hfb: o_byte = 8'h63; 8'hfc: o_byte = 8'h55; 8'hfd: o_byte = 8'h21; 8'hfe: o_byte = 8'h0c; 8'hff: o_byte = 8'h7d;
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Byte-serial InvSubBytes engine: accepts one 128-bit state, substitutes
// LANES bytes per clock through shared inverse S-boxes, then hands the
// result downstream. Trades latency (16/LANES cycles) for S-box count.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    inv_sub_bytes_seq_if.slave  bus
);

    localparam int NGROUPS = AES_NBYTES / LANES;
    localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NGROUPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    seq_state_e             r_fsm;
    logic [CNT_W-1:0]       r_grp_cnt;
    logic [AES_STATE_W-1:0] r_state;
    logic                   r_out_valid;
    logic                   r_in_ready;
    logic                   r_busy;

    // Per lane, the byte each group presents to that lane's S-box.
    logic [AES_BYTE_W-1:0]  w_lane_grp [LANES][NGROUPS];
    logic [AES_BYTE_W-1:0]  w_sbox_in  [LANES];
    logic [AES_BYTE_W-1:0]  w_sbox_out [LANES];
    logic [AES_STATE_W-1:0] w_state_upd;

    // Byte b belongs to group b/LANES and is handled by lane b%LANES; only
    // the bytes of the active group are replaced, the rest pass through.
    for (genvar b = 0; b < AES_NBYTES; b++) begin : g_byte
        localparam int LSB  = byte_lsb(b);
        localparam int GRP  = b / LANES;
        localparam int LANE = b % LANES;

        assign w_lane_grp[LANE][GRP] = r_state[LSB +: AES_BYTE_W];
        assign w_state_upd[LSB +: AES_BYTE_W] = (r_grp_cnt == CNT_W'(GRP)) ?
                                                w_sbox_out[LANE] :
                                                r_state[LSB +: AES_BYTE_W];
    end

    // One shared S-box per lane, fed from the byte of the current group.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_sbox_in[l] = w_lane_grp[l][r_grp_cnt];

        inv_sbox u_inv_sbox (
            .i_byte (w_sbox_in[l]),
            .o_byte (w_sbox_out[l])
        );
    end

    // Engine FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= SEQ_IDLE;
            r_grp_cnt   <= '0;
            r_state     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                SEQ_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_state    <= bus.in_state;
                        r_grp_cnt  <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_fsm      <= SEQ_BUSY;
                    end
                end
                SEQ_BUSY: begin
                    r_state <= w_state_upd;
                    if (r_grp_cnt == LAST_GRP) begin
                        r_grp_cnt   <= '0;
                        r_out_valid <= 1'b1;
                        r_fsm       <= SEQ_DONE;
                    end else begin
                        r_grp_cnt <= r_grp_cnt + CNT_W'(1);
                    end
                end
                SEQ_DONE: begin
                    // in_ready only returns after the result has left, so a
                    // new state is never taken in the same cycle.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_fsm       <= SEQ_IDLE;
                    end
                end
                default: begin
                    r_fsm       <= SEQ_IDLE;
                    r_grp_cnt   <= '0;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_state = r_state;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq with LANES = 1, 4 and 16.
module tb_inv_sub_bytes_seq;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic         in_valid_a  [3];
    logic [127:0] in_state_a  [3];
    logic         out_ready_a [3];
    logic         in_ready_a  [3];
    logic         out_valid_a [3];
    logic         busy_a      [3];
    logic [127:0] out_state_a [3];

    logic [7:0]   fsbox [256];
    logic [2047:0] fs_flat;
    logic [127:0] exp_q0 [$];
    logic [127:0] exp_q1 [$];
    logic [127:0] exp_q2 [$];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 1 : ((k == 1) ? 4 : 16);
        inv_sub_bytes_seq_if u_if ();
        assign u_if.in_valid  = in_valid_a[k];
        assign u_if.in_state  = in_state_a[k];
        assign u_if.out_ready = out_ready_a[k];
        assign in_ready_a[k]  = u_if.in_ready;
        assign out_valid_a[k] = u_if.out_valid;
        assign out_state_a[k] = u_if.out_state;
        assign busy_a[k]      = u_if.busy;
        inv_sub_bytes_seq #(.LANES(L)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if));
    end

    function automatic int lanes_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
    endfunction

    // Forward SubBytes model used to build inputs whose inverse is known.
    function automatic logic [127:0] fwd_state(input logic [127:0] p);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = fsbox[p[127-8*i -: 8]];
        return r;
    endfunction

    function automatic void sb_push(input int k, input logic [127:0] v);
        case (k)
            0: exp_q0.push_back(v);
            1: exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endfunction

    function automatic logic [127:0] sb_pop(input int k);
        logic [127:0] v;
        v = {128{1'bx}};
        case (k)
            0: if (exp_q0.size() > 0) v = exp_q0.pop_front();
            1: if (exp_q1.size() > 0) v = exp_q1.pop_front();
            default: if (exp_q2.size() > 0) v = exp_q2.pop_front();
        endcase
        return v;
    endfunction

    // Present one state, wait for the accepting edge, record its expectation.
    task automatic send(input int k, input logic [127:0] st, input logic [127:0] exp_v, output bit ok);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready_a[k] && w < 50) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready_a[k];
        in_valid_a[k] = 1'b1;
        in_state_a[k] = st;
        if (ok) sb_push(k, exp_v);
        @(posedge clk);
        #1;
        in_valid_a[k] = 1'b0;
    endtask

    // Count edges until out_valid is seen (bounded).
    task automatic wait_out(input int k, output int lat);
        lat = 0;
        while (!out_valid_a[k] && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (in_ready_a[k] !== 1'b1 || out_valid_a[k] !== 1'b0 || busy_a[k] !== 1'b0 || out_state_a[k] !== 128'h0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: got rdy=%b vld=%b busy=%b st=%h required 1 0 0 0", k, in_ready_a[k], out_valid_a[k], busy_a[k], out_state_a[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_release: got rdy=%b busy=%b required 1 0", in_ready_a[0], busy_a[0]);
        end
    endtask

    task automatic test_row0();
        bit ok;
        int lat;
        logic [127:0] exp_v;
        out_ready_a[0] = 1'b1;
        send(0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, ok);
        n_checks++;
        if (!ok || in_ready_a[0] !== 1'b0 || busy_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL row0_accept: got ok=%b rdy=%b busy=%b required 1 0 1", ok, in_ready_a[0], busy_a[0]);
        end
        wait_out(0, lat);
        n_checks++;
        if (lat !== 16) begin
            n_fail++;
            $display("FAIL row0_latency: got %0d required 16", lat);
        end
        exp_v = sb_pop(0);
        n_checks++;
        if (out_state_a[0] !== exp_v) begin
            n_fail++;
            $display("FAIL row0_data: got %h required %h", out_state_a[0], exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_trip();
        bit ok;
        int lat;
        logic [127:0] p;
        logic [127:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            out_ready_a[k] = 1'b1;
            for (int j = 0; j < 16; j++) begin
                for (int i = 0; i < 16; i++) p[127-8*i -: 8] = 8'(16*j + i);
                send(k, fwd_state(p), p, ok);
                wait_out(k, lat);
                n_checks++;
                if (!ok || lat !== 16 / lanes_of(k)) begin
                    n_fail++;
                    $display("FAIL round_trip_latency dut%0d job%0d: got %0d (accepted=%b) required %0d", k, j, lat, ok, 16 / lanes_of(k));
                end
                exp_v = sb_pop(k);
                n_checks++;
                if (out_state_a[k] !== exp_v) begin
                    n_fail++;
                    $display("FAIL round_trip_data dut%0d job%0d: got %h required %h", k, j, out_state_a[k], exp_v);
                end
                @(posedge clk);
                #1;
                n_checks++;
                if (out_valid_a[k] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL round_trip_release dut%0d job%0d: got out_valid=%b required 0", k, j, out_valid_a[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [127:0] exp_v;
        out_ready_a[0] = 1'b0;
        send(0, 128'h0, {16{8'h52}}, ok);
        wait_out(0, lat);
        n_checks++;
        if (!ok || out_valid_a[0] !== 1'b1 || lat !== 16) begin
            n_fail++;
            $display("FAIL bp_arrival: got vld=%b lat=%0d required 1 16", out_valid_a[0], lat);
        end
        exp_v = sb_pop(0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_state_a[0] !== exp_v || out_valid_a[0] !== 1'b1 || in_ready_a[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle%0d: got st=%h vld=%b rdy=%b required %h 1 0", c, out_state_a[0], out_valid_a[0], in_ready_a[0], exp_v);
            end
        end
        out_ready_a[0] = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got vld=%b rdy=%b required 0 1", out_valid_a[0], in_ready_a[0]);
        end
    endtask

    task automatic test_ignored_input();
        bit ok;
        int lat;
        int extra;
        logic [127:0] exp_v;
        out_ready_a[0] = 1'b1;
        send(0, {16{8'h63}}, 128'h0, ok);
        repeat (3) @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_state_a[0] = {16{8'hff}};
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        wait_out(0, lat);
        exp_v = sb_pop(0);
        n_checks++;
        if (!ok || out_valid_a[0] !== 1'b1 || out_state_a[0] !== exp_v) begin
            n_fail++;
            $display("FAIL ignored_data: got vld=%b st=%h required 1 %h", out_valid_a[0], out_state_a[0], exp_v);
        end
        @(posedge clk);
        #1;
        extra = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (out_valid_a[0] === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0 || in_ready_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_single_txn: got extra_valid_cycles=%0d rdy=%b required 0 1", extra, in_ready_a[0]);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        int lat;
        logic [127:0] exp_v;
        out_ready_a[0] = 1'b1;
        send(0, {16{8'h5a}}, {16{8'h46}}, ok);
        repeat (7) @(posedge clk);
        #2;
        n_checks++;
        if (busy_a[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_busy: got %b required 1", busy_a[0]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || out_state_a[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL mid_reset_values: got rdy=%b vld=%b busy=%b st=%h required 1 0 0 0", in_ready_a[0], out_valid_a[0], busy_a[0], out_state_a[0]);
        end
        exp_q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, {16{8'h16}}, {16{8'hff}}, ok);
        wait_out(0, lat);
        exp_v = sb_pop(0);
        n_checks++;
        if (!ok || lat !== 16 || out_state_a[0] !== exp_v) begin
            n_fail++;
            $display("FAIL post_reset_job: got lat=%0d st=%h required 16 %h", lat, out_state_a[0], exp_v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [127:0] pa;
        logic [127:0] pb;
        logic [127:0] exp_v;
        int acc_t [2];
        int n_acc;
        int n_out;
        pa = {$urandom, $urandom, $urandom, $urandom};
        pb = {$urandom, $urandom, $urandom, $urandom};
        n_acc = 0;
        n_out = 0;
        acc_t[0] = -100;
        acc_t[1] = 100;
        out_ready_a[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            in_state_a[0] = (n_acc >= 1) ? fwd_state(pb) : fwd_state(pa);
            in_valid_a[0] = (n_acc < 2);
            if (out_valid_a[0] === 1'b1) begin
                n_out++;
                exp_v = sb_pop(0);
                n_checks++;
                if (out_state_a[0] !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_data out%0d: got %h required %h", n_out, out_state_a[0], exp_v);
                end
            end
            if (in_valid_a[0] && in_ready_a[0] === 1'b1) begin
                if (n_acc < 2) acc_t[n_acc] = c;
                sb_push(0, (n_acc == 0) ? pa : pb);
                n_acc++;
            end
        end
        in_valid_a[0] = 1'b0;
        n_checks++;
        if (n_acc !== 2 || n_out !== 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got accepts=%0d outputs=%0d required 2 2", n_acc, n_out);
        end
        n_checks++;
        if (acc_t[1] - acc_t[0] !== 18) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d required 18", acc_t[1] - acc_t[0]);
        end
    endtask

    initial begin
        fs_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) fsbox[i] = fs_flat[2047-8*i -: 8];
        for (int k = 0; k < 3; k++) begin
            in_valid_a[k]  = 1'b0;
            in_state_a[k]  = 128'h0;
            out_ready_a[k] = 1'b0;
        end
        test_reset();
        test_row0();
        test_round_trip();
        test_backpressure();
        test_ignored_input();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Byte-serial InvSubBytes engine for the AES decryption datapath. It accepts one 128-bit state over a valid/ready handshake. It applies the inverse S-box to LANES bytes per clock, using LANES shared inv_sbox instances. It returns the substituted state over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the iterative decrypt round, trading latency for S-box area.

Parameters:
LANES, 1, bytes substituted per clock; legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
NGROUPS, 16/LANES, derived local constant; number of BUSY cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_state is valid
in_ready  output  1  block can accept a state
in_state  input  128  ciphertext-side state; byte 0 = [127:120], byte 15 = [7:0]
out_valid  output  1  out_state holds a finished result
out_ready  input  1  downstream accepts out_state
out_state  output  128  InvSubBytes(in_state), same byte order
busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, grp_cnt=0, state_reg=0, out_valid=0, in_ready=1, busy=0, out_state=0.
- FSM states: IDLE, BUSY, DONE. All outputs are driven from registers or decoded from the FSM state; there is no combinational path from in_* to out_*.
- IDLE: in_ready=1. When in_valid and in_ready are both high at an edge: state_reg<=in_state, grp_cnt<=0, go to BUSY.
- BUSY: in_ready=0. Each edge replaces bytes [grp_cnt*LANES .. grp_cnt*LANES+LANES-1] of state_reg with their inverse S-box values, then increments grp_cnt. On the edge that processes group NGROUPS-1: go to DONE, set out_valid<=1, and clear grp_cnt to 0. grp_cnt never wraps beyond NGROUPS-1.
- Latency: out_valid is high exactly NGROUPS edges after the accepting edge (16 for LANES=1, 1 for LANES=16).
- DONE: out_valid=1 and out_state=state_reg. out_state is held stable while out_ready=0, with no limit on stall length. When out_valid and out_ready are both high at an edge: out_valid<=0, go to IDLE. in_ready rises in the following cycle; there is no same-cycle accept in DONE.
- in_valid while in BUSY or DONE is ignored and in_state is not sampled. in_state only needs to be stable on the accepting edge.
- rst_n asserted mid-operation: immediate return to reset values; the partial result is discarded and no out_valid pulse occurs.
- inv_sbox mapping is the FIPS-197 inverse table, including 0x63->0x00, 0x00->0x52, 0x16->0xFF and 0xFF->0x7D.

Decomposition:
- Shared package aes_pkg:
  - AES_BYTE_W=8, AES_STATE_W=128, AES_NBYTES=16;
  - byte-index-to-slice helper function;
  - FSM state enum, shared with the other serial round engines.
- Sub-module inv_sbox: combinational, 8-bit in, 8-bit out, 256-entry case table; instantiated LANES times.
- Byte-select muxing and the FSM stay in inv_sub_bytes_seq.

Test Plan:
- Row-0 vector, LANES=1: in_state=637c777bf26b6fc53001672bfed7ab76 -> out_state=000102030405060708090a0b0c0d0e0f; out_valid rises exactly 16 cycles after accept.
- Exhaustive round trip: drive 16 states built from the forward SBox of bytes 00..ff, with out_ready=1 -> every out byte equals its original index; repeat for LANES=1, 4 and 16 (expected latencies 16, 4 and 1).
- Backpressure: state all 0x00, hold out_ready=0 for 20 cycles -> out_state stays 5252...52, out_valid stays high and in_ready stays low; release out_ready -> out_valid falls and in_ready is high next cycle.
- Ignored input: pulse in_valid with ffff...ff during BUSY of a 6363...63 job -> result is 0000...00 and only one output transaction occurs.
- Mid-operation reset: assert rst_n=0 at BUSY cycle 7 -> all outputs return to reset values asynchronously; after release, a new all-0x16 job yields ffff...ff with normal latency.
- Back-to-back: two jobs with in_valid and out_ready held high -> accepts are separated by NGROUPS+2 cycles and both results are correct and in order.
